uart_tx: RTL and testbench

UART transmitter, 8N1 framing, fixed baud rate derived from the system clock. Bytes are accepted over a valid/ready byte interface into a small internal FIFO and serialised on `tx`. It is the transmit counterpart of the receive path that feeds the VGA text display. It sits in `uart_top` beside that receive path, so the board can echo or report status over the same serial link.

---
 rtl/uart_tx.sv | 178 +++++++++++++++++
 tb/tb_uart_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serialiser.
// Line rate is CLK_FREQ / BAUD clocks per bit, truncated.
module uart_tx #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam int unsigned PtrW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned FillW      = PtrW + 1;

  localparam logic [CntW-1:0]  BitLast = CntW'(ClksPerBit - 1);
  localparam logic [FillW-1:0] Full    = FillW'(FIFO_DEPTH);

  if (ClksPerBit < 2) begin : gen_baud_check
    $error("uart_tx: CLK_FREQ / BAUD must be at least 2");
  end

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_depth_check
    $error("uart_tx: FIFO_DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;

  logic [FillW-1:0] count_q, count_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic bit_done;

  // No bypass: acceptance depends only on the registered fill level.
  assign tx_ready = (count_q != Full);
  assign push     = tx_valid && tx_ready;
  assign bit_done = (bit_cnt_q == BitLast);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (count_q != '0) begin
            pop       = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            bit_idx_d = '0;
            state_d   = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // tx and busy are registered from the current state, so both trail the FSM
  // by one cycle and stay aligned with each other on the line.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      StIdle:  tx_d = 1'b1;
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_q[0];
      StStop:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_q != StIdle) || (count_q != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the flushed pointers and count make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed and randomized checks of uart_tx against a byte-queue model and an
// ideal 8N1 waveform computed per byte.
module tb_uart_tx;

  localparam int unsigned ClkFreq  = 1_000_000;
  localparam int unsigned Baud     = 250_000;
  localparam int unsigned Depth    = 4;
  localparam int unsigned Cpb      = ClkFreq / Baud;
  localparam int          FrameCyc = 10 * Cpb;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  logic [7:0] exp_q[$];

  uart_tx #(
    .CLK_FREQ  (ClkFreq),
    .BAUD      (Baud),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Ideal line waveform for one frame, one entry per clock: start, 8 data LSB first, stop.
  function automatic logic [FrameCyc-1:0] frame_wave(input logic [7:0] b);
    logic [FrameCyc-1:0] w;
    int p;
    for (int i = 0; i < FrameCyc; i++) begin
      p = i / Cpb;
      if (p == 0)      w[i] = 1'b0;
      else if (p <= 8) w[i] = b[p-1];
      else             w[i] = 1'b1;
    end
    return w;
  endfunction

  // Offers one byte and returns the cycle stamp of the accepting edge.
  task automatic push(input logic [7:0] b, output int acc);
    int waited = 0;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("push_accept_in_time", 64'(waited < 200), 64'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    exp_q.push_back(b);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Waits for a start bit, records a whole frame and compares it with the model's next byte.
  task automatic expect_frame(input string tag, output int start);
    logic [FrameCyc-1:0] w;
    logic [7:0] e;
    bit found = 1'b0;
    start = -1;
    w = '1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_found"}, 64'(found), 64'd1);
    if (found) begin
      start = cyc;
      w[0] = tx;
      for (int k = 1; k < FrameCyc; k++) begin
        @(negedge clk);
        w[k] = tx;
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      check({tag, "_wave"}, 64'(w), 64'(frame_wave(e)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, c, s1, s2, s3, lows;
    int acc[6];
    int t3_off[6] = '{0, 1, 2, 3, 4, 42};
    logic [FrameCyc-1:0] w3c;

    // Reset with inputs active: they must be ignored.
    tx_valid = 1'b1;
    tx_data  = 8'($urandom);
    repeat (3) @(negedge clk);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(tx_ready), 64'd1);
    rst = 1'b1;
    tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_tx", 64'(tx), 64'd1);
    check("post_rst_busy", 64'(busy), 64'd0);

    // 1: single byte latency, waveform and busy release.
    push(8'hA5, a);
    idle_inputs();
    expect_frame("t1", s1);
    check("t1_latency", 64'(s1), 64'(a + 2));
    check("t1_busy_last_stop", 64'(busy), 64'd1);
    @(negedge clk);
    check("t1_busy_after", 64'(busy), 64'd0);
    check("t1_tx_idle", 64'(tx), 64'd1);

    // 2: back-to-back frames with no idle gap.
    push(8'h00, a);
    push(8'hFF, b);
    idle_inputs();
    check("t2_consecutive", 64'(b), 64'(a + 1));
    expect_frame("t2a", s1);
    expect_frame("t2b", s2);
    check("t2_latency", 64'(s1), 64'(a + 2));
    check("t2_no_gap", 64'(s2), 64'(s1 + FrameCyc));
    repeat (2) @(negedge clk);
    check("t2_busy_after", 64'(busy), 64'd0);

    // 3: fill the FIFO while the first byte transmits.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          push(8'(i + 1), acc[i]);
          if (i == 4) begin
            @(negedge clk);
            check("t3_ready_full", 64'(tx_ready), 64'd0);
          end
        end
        idle_inputs();
      end
      begin
        int s;
        for (int f = 0; f < 6; f++) expect_frame("t3", s);
      end
    join
    for (int i = 1; i < 6; i++) check("t3_accept_time", 64'(acc[i] - acc[0]), 64'(t3_off[i]));
    check("t3_queue_drained", 64'(exp_q.size()), 64'd0);

    // 4: reset during data bit 3 of the first of two queued frames.
    push(8'h3C, a);
    push(8'h55, b);
    idle_inputs();
    wait_cyc(a + 2 + 17);
    w3c = frame_wave(8'h3C);
    check("t4_busy_before", 64'(busy), 64'd1);
    check("t4_tx_bit3", 64'(tx), 64'(w3c[17]));
    rst = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'($urandom);
    #1;
    check("t4_tx_async", 64'(tx), 64'd1);
    check("t4_busy_async", 64'(busy), 64'd0);
    check("t4_ready_async", 64'(tx_ready), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    tx_valid = 1'b0;
    exp_q.delete();
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("t4_no_frame", 64'(lows), 64'd0);
    check("t4_ready_after", 64'(tx_ready), 64'd1);
    check("t4_busy_after", 64'(busy), 64'd0);

    // 5: push of 0x33 lands on the edge that pops 0x22.
    push(8'h11, a);
    idle_inputs();
    fork
      begin
        wait_cyc(a + 4);
        push(8'h22, b);
        idle_inputs();
        wait_cyc(a + 39);
        push(8'h33, c);
        idle_inputs();
        check("t5_push_on_pop", 64'(c), 64'(a + 41));
      end
      begin
        expect_frame("t5a", s1);
        expect_frame("t5b", s2);
        expect_frame("t5c", s3);
      end
    join
    check("t5_latency", 64'(s1), 64'(a + 2));
    check("t5_gap_ab", 64'(s2), 64'(s1 + FrameCyc));
    check("t5_gap_bc", 64'(s3), 64'(s2 + FrameCyc));

    // 6: spaced single bytes walking the pointers past the wrap.
    for (int i = 0; i < 9; i++) begin
      push(8'(8'h80 + i), a);
      idle_inputs();
      expect_frame("t6", s1);
      check("t6_latency", 64'(s1), 64'(a + 2));
      wait_cyc(a + 58);
      check("t6_busy_gap", 64'(busy), 64'd0);
    end

    // Randomized bursts: random bytes and random gaps, line order must match.
    for (int r = 0; r < 3; r++) begin
      fork
        begin
          for (int i = 0; i < 5; i++) begin
            push(8'($urandom), b);
            if ($urandom_range(0, 1) == 1) begin
              idle_inputs();
              repeat ($urandom_range(0, 30)) @(negedge clk);
            end
          end
          idle_inputs();
        end
        begin
          int s;
          for (int f = 0; f < 5; f++) expect_frame("rnd", s);
        end
      join
      repeat (4) @(negedge clk);
      check("rnd_busy_done", 64'(busy), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
